// File: rtl/delay_sweep_sched.sv
// Steps the pulse-generator echo delay through a programmed sweep, advancing only on Sync shot boundaries.
// Optional build macro SWEEP_LOOP_EN: restart the sweep from the base delay instead of stopping in DONE.
module delay_sweep_sched #(
    parameter int DW = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] base_del,
    input  logic [DW-1:0] step_del,
    input  logic [CW-1:0] n_steps,
    input  logic [CW-1:0] n_avg,
    input  logic          sync_in,
    output logic [DW-1:0] del_out,
    output logic          upd,
    output logic [CW-1:0] step_idx,
    output logic          busy,
    output logic          done,
    output logic          ovf_err
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

    state_t        state;
    logic          sync_meta, sync_s2, sync_s3, sync_edge;
    logic [DW-1:0] base_sh, step_sh;
    logic [CW-1:0] steps_sh, avg_sh, avg_cnt;
    logic [CW-1:0] steps_last, avg_last;
    logic [DW:0]   sum_full;
    logic          upd_pend, upd_ev, upd_req, last_point;

    function automatic logic [DW-1:0] sat_clamp(input logic [DW:0] s);
        return s[DW] ? {DW{1'b1}} : s[DW-1:0];
    endfunction

    // Sync crosses from the PLL domain; the registered edge pulse lands 3 cycles after the rise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_meta <= 1'b0;
            sync_s2   <= 1'b0;
            sync_s3   <= 1'b0;
            sync_edge <= 1'b0;
        end else begin
            sync_meta <= sync_in;
            sync_s2   <= sync_meta;
            sync_s3   <= sync_s2;
            sync_edge <= sync_s2 & ~sync_s3;
        end
    end

    always_comb begin
        steps_last = (steps_sh == '0) ? '0 : steps_sh - 1'b1;
        avg_last   = (avg_sh == '0) ? '0 : avg_sh - 1'b1;
        sum_full   = {1'b0, del_out} + {1'b0, step_sh};
        last_point = (step_idx >= steps_last);
        upd_ev     = 1'b0;
        if ((state == S_IDLE || state == S_DONE) && start && !abort)
            upd_ev = 1'b1;
        else if ((state == S_ARM || state == S_RUN) && abort)
            upd_ev = 1'b1;
        else if (state == S_RUN && sync_edge && avg_cnt >= avg_last) begin
`ifdef SWEEP_LOOP_EN
            upd_ev = 1'b1;
`else
            upd_ev = !last_point;
`endif
        end
        upd_req = upd_ev | upd_pend;
    end

    // A change requested right after a strobe is deferred one cycle so upd never stays high twice.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            del_out  <= '0;
            upd      <= 1'b0;
            upd_pend <= 1'b0;
            step_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf_err  <= 1'b0;
            avg_cnt  <= '0;
            base_sh  <= '0;
            step_sh  <= '0;
            steps_sh <= '0;
            avg_sh   <= '0;
        end else begin
            upd      <= upd_req & ~upd;
            upd_pend <= upd_req & upd;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start && !abort) begin
                        base_sh  <= base_del;
                        step_sh  <= step_del;
                        steps_sh <= n_steps;
                        avg_sh   <= n_avg;
                        del_out  <= base_del;
                        step_idx <= '0;
                        ovf_err  <= 1'b0;
                        avg_cnt  <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        state    <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (abort) begin
                        del_out  <= base_sh;
                        step_idx <= '0;
                        avg_cnt  <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (sync_edge) begin
                        // This shot may have been launched with the previous delay.
                        avg_cnt <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        del_out  <= base_sh;
                        step_idx <= '0;
                        avg_cnt  <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (sync_edge) begin
                        if (avg_cnt < avg_last) begin
                            avg_cnt <= avg_cnt + 1'b1;
                        end else if (!last_point) begin
                            avg_cnt  <= '0;
                            step_idx <= step_idx + 1'b1;
                            del_out  <= sat_clamp(sum_full);
                            if (sum_full[DW])
                                ovf_err <= 1'b1;
                        end else begin
`ifdef SWEEP_LOOP_EN
                            del_out  <= base_sh;
                            step_idx <= '0;
                            avg_cnt  <= '0;
                            state    <= S_ARM;
`else
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_DONE;
`endif
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_sweep_sched.sv
// Randomised and directed bench for delay_sweep_sched against an edge-count reference model.
`timescale 1ns/1ps
module tb_delay_sweep_sched;
    localparam int DW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          sync_in = 1'b0;
    logic [DW-1:0] base_del = '0;
    logic [DW-1:0] step_del = '0;
    logic [CW-1:0] n_steps = '0;
    logic [CW-1:0] n_avg = '0;
    logic [DW-1:0] del_out;
    logic          upd;
    logic [CW-1:0] step_idx;
    logic          busy, done, ovf_err;

    delay_sweep_sched #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .base_del(base_del), .step_del(step_del), .n_steps(n_steps), .n_avg(n_avg),
        .sync_in(sync_in), .del_out(del_out), .upd(upd), .step_idx(step_idx),
        .busy(busy), .done(done), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int upd_cnt = 0;
    int upd_dbl = 0;
    logic upd_prev = 1'b0;

    // Reference state: sweep parameters and number of Sync edges seen since start.
    int m_base, m_step, m_pts, m_avg, m_n, m_max_idx, m_upd;

    logic [26:0] act_vec, exp_vec;
    assign act_vec = {del_out, step_idx, busy, done, ovf_err};

    always @(posedge clk) begin
        #2;
        if (upd === 1'b1) upd_cnt++;
        if (upd === 1'b1 && upd_prev === 1'b1) upd_dbl++;
        upd_prev = upd;
    end

    function automatic int model_idx(int n);
        int p, m;
        p = m_pts * m_avg;
        if (n == 0) return 0;
`ifdef SWEEP_LOOP_EN
        m = (n - 1) % (p + 1);
        if (m == p) return 0;
        return m / m_avg;
`else
        m = n - 1;
        if (m >= p) return m_pts - 1;
        return m / m_avg;
`endif
    endfunction

    function automatic bit model_event(int n);
        int p, m;
        p = m_pts * m_avg;
        if (n == 0) return 1'b0;
`ifdef SWEEP_LOOP_EN
        m = (n - 1) % (p + 1);
        return (m >= 1) && (m % m_avg == 0);
`else
        m = n - 1;
        return (m >= 1) && (m < p) && (m % m_avg == 0);
`endif
    endfunction

    function automatic bit model_done(int n);
`ifdef SWEEP_LOOP_EN
        return 1'b0;
`else
        return (n >= 1) && (n - 1 >= m_pts * m_avg);
`endif
    endfunction

    function automatic logic [26:0] model_vec();
        int idx, sum;
        logic [15:0] d;
        logic ov, dn;
        idx = model_idx(m_n);
        sum = m_base + idx * m_step;
        d   = (sum > 65535) ? 16'hFFFF : sum[15:0];
        ov  = (m_base + m_max_idx * m_step) > 65535;
        dn  = model_done(m_n);
        return {d, idx[7:0], ~dn, dn, ov};
    endfunction

    task automatic go_idle();
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic drive_start(input int b, input int s, input int ns, input int na);
        @(negedge clk);
        m_upd = upd_cnt + 1;
        base_del = 16'(b); step_del = 16'(s); n_steps = 8'(ns); n_avg = 8'(na);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_base = b; m_step = s;
        m_pts = (ns == 0) ? 1 : ns;
        m_avg = (na == 0) ? 1 : na;
        m_n = 0; m_max_idx = 0;
    endtask

    task automatic send_edge();
        int idx;
        @(negedge clk); sync_in = 1'b1;
        @(negedge clk);
        @(negedge clk); sync_in = 1'b0;
        repeat (4) @(negedge clk);
        m_n++;
        idx = model_idx(m_n);
        if (idx > m_max_idx) m_max_idx = idx;
        if (model_event(m_n)) m_upd++;
    endtask

    task automatic test_reset();
        #3 resetn = 1'b0;
        #1;
        total++;
        if (act_vec !== 27'd0 || upd !== 1'b0) begin
            bad++; $display("FAIL reset_state: got %h/%b want 0/0", act_vec, upd);
        end
        @(negedge clk); resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        drive_start(100, 10, 3, 2);
        exp_vec = model_vec();
        total++;
        if (act_vec !== exp_vec || upd !== 1'b1) begin
            bad++; $display("FAIL basic_start: got %h upd=%b want %h upd=1", act_vec, upd, exp_vec);
        end
        for (int e = 1; e <= 8; e++) begin
            send_edge();
            exp_vec = model_vec();
            total++;
            if (act_vec !== exp_vec) begin
                bad++; $display("FAIL basic_edge%0d: got %h want %h", e, act_vec, exp_vec);
            end
        end
        total++;
        if (upd_cnt !== m_upd || upd_dbl !== 0) begin
            bad++; $display("FAIL basic_upd: got cnt=%0d dbl=%0d want cnt=%0d dbl=0", upd_cnt, upd_dbl, m_upd);
        end
    endtask

    task automatic test_zero_counts();
        go_idle();
        drive_start(50, 7, 0, 0);
        for (int e = 1; e <= 2; e++) begin
            send_edge();
            exp_vec = model_vec();
            total++;
            if (act_vec !== exp_vec) begin
                bad++; $display("FAIL zero_edge%0d: got %h want %h", e, act_vec, exp_vec);
            end
        end
        total++;
        if (upd_cnt !== m_upd) begin
            bad++; $display("FAIL zero_upd: got %0d want %0d", upd_cnt, m_upd);
        end
    endtask

    task automatic test_saturation();
        go_idle();
        drive_start(16'hFFF0, 16'h0020, 2, 1);
        for (int e = 1; e <= 3; e++) begin
            send_edge();
            exp_vec = model_vec();
            total++;
            if (act_vec !== exp_vec) begin
                bad++; $display("FAIL sat_edge%0d: got %h want %h", e, act_vec, exp_vec);
            end
        end
        go_idle();
        drive_start(100, 10, 3, 2);
        exp_vec = model_vec();
        total++;
        if (act_vec !== exp_vec) begin
            bad++; $display("FAIL sat_restart_clears: got %h want %h", act_vec, exp_vec);
        end
    endtask

    task automatic test_abort();
        go_idle();
        drive_start(100, 10, 3, 2);
        for (int e = 1; e <= 3; e++) send_edge();
        exp_vec = model_vec();
        total++;
        if (act_vec !== exp_vec) begin
            bad++; $display("FAIL abort_pre: got %h want %h", act_vec, exp_vec);
        end
        // abort is held exactly in the cycle the registered sync edge is consumed
        @(negedge clk); sync_in = 1'b1;
        @(negedge clk);
        @(negedge clk); sync_in = 1'b0;
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        m_upd++;
        exp_vec = {16'd100, 8'd0, 1'b0, 1'b0, 1'b0};
        total++;
        if (act_vec !== exp_vec || upd !== 1'b1) begin
            bad++; $display("FAIL abort_now: got %h upd=%b want %h upd=1", act_vec, upd, exp_vec);
        end
        repeat (6) @(negedge clk);
        total++;
        if (act_vec !== exp_vec || upd_cnt !== m_upd) begin
            bad++; $display("FAIL abort_hold: got %h upd_cnt=%0d want %h upd_cnt=%0d", act_vec, upd_cnt, exp_vec, m_upd);
        end
    endtask

    task automatic test_ignored_start();
        go_idle();
        drive_start(200, 5, 3, 1);
        for (int e = 1; e <= 2; e++) send_edge();
        @(negedge clk);
        base_del = 16'd999; step_del = 16'(32'($urandom_range(1, 900)));
        n_steps = 8'd7; n_avg = 8'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        exp_vec = model_vec();
        total++;
        if (act_vec !== exp_vec) begin
            bad++; $display("FAIL ignored_start: got %h want %h", act_vec, exp_vec);
        end
        for (int e = 3; e <= 5; e++) begin
            send_edge();
            exp_vec = model_vec();
            total++;
            if (act_vec !== exp_vec) begin
                bad++; $display("FAIL ignored_edge%0d: got %h want %h", e, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        int b, s, ns, na, edges;
        for (int it = 0; it < 5; it++) begin
            go_idle();
            b  = int'($urandom_range(0, 65535));
            s  = int'($urandom_range(0, 20000));
            ns = int'($urandom_range(0, 4));
            na = int'($urandom_range(0, 3));
            drive_start(b, s, ns, na);
            edges = m_pts * m_avg + 2;
            for (int e = 1; e <= edges; e++) begin
                send_edge();
                exp_vec = model_vec();
                total++;
                if (act_vec !== exp_vec) begin
                    bad++; $display("FAIL rand%0d_edge%0d: got %h want %h", it, e, act_vec, exp_vec);
                end
            end
            total++;
            if (upd_cnt !== m_upd) begin
                bad++; $display("FAIL rand%0d_upd: got %0d want %0d", it, upd_cnt, m_upd);
            end
        end
        total++;
        if (upd_dbl !== 0) begin
            bad++; $display("FAIL upd_back_to_back: got %0d want 0", upd_dbl);
        end
    endtask

    task automatic test_reset_mid_run();
        go_idle();
        drive_start(100, 10, 3, 2);
        for (int e = 1; e <= 3; e++) send_edge();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        total++;
        if (act_vec !== 27'd0 || upd !== 1'b0) begin
            bad++; $display("FAIL reset_mid_run: got %h/%b want 0/0", act_vec, upd);
        end
        @(negedge clk); resetn = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (act_vec !== 27'd0) begin
            bad++; $display("FAIL reset_stays_idle: got %h want 0", act_vec);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_counts();
        test_saturation();
        test_abort();
        test_ignored_start();
        test_random();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/delay_sweep_sched.md
Name: delay_sweep_sched

Overview:
- Scheduler that drives the echo-delay input of the pulse generator through a programmed sweep.
- Steps the delay by a fixed increment after a programmed number of averaged shots.
- Each step changes only at a shot boundary, marked by the rising edge of the generator's Sync output.
- Sits between the serial control block and the pulse generator on the 12 MHz control clock.

Parameters:
- DW, 16, width of the delay words (base, step, output).
- CW, 8, width of the step-count and average-count fields.

Ports:
- clk  in  1  control clock (12 MHz).
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep.
- abort  in  1  one-cycle request to stop the sweep and restore the base delay.
- base_del  in  DW  first delay value, in PLL clock ticks.
- step_del  in  DW  increment added per step.
- n_steps  in  CW  number of delay points; 0 is treated as 1.
- n_avg  in  CW  shots per delay point; 0 is treated as 1.
- sync_in  in  1  Sync output of the pulse generator (PLL domain, asynchronous to clk).
- del_out  out  DW  delay fed to the pulse generator.
- upd  out  1  one-cycle strobe whenever del_out changes.
- step_idx  out  CW  index of the current delay point.
- busy  out  1  high in ARM or RUN.
- done  out  1  high in DONE.
- ovf_err  out  1  sticky delay-saturation flag.

Behaviour:
- Reset values: del_out=0, upd=0, step_idx=0, busy=0, done=0, ovf_err=0; state=IDLE; internal counters 0.
- sync_in handling:
  - Passes through a 2-flop synchroniser plus an edge-detect flop.
  - sync_edge is asserted 3 clk cycles after a sync_in rise, for one cycle.
- States: IDLE, ARM, RUN, DONE.
- IDLE / DONE on start:
  - Latch base_del, step_del, n_steps, n_avg into shadow registers.
  - del_out<=base_del, step_idx<=0, ovf_err<=0, avg_cnt<=0, upd=1 the next cycle, state<=ARM.
  - Shadow registers are used for the rest of the sweep; input changes mid-sweep are ignored.
- ARM: the first sync_edge is discarded, because that shot may have started with the old delay. Then go to RUN with avg_cnt=0.
- RUN, on each sync_edge:
  - If avg_cnt < n_avg_eff-1: increment avg_cnt.
  - Else if step_idx < n_steps_eff-1: avg_cnt<=0, step_idx++, del_out<=sat(del_out+step_del), upd=1.
  - Else: state<=DONE. del_out holds its last value.
- Arithmetic: the sum is computed DW+1 bits wide. On carry, del_out clamps to all-ones and ovf_err sets. Clamped steps still count.
- start while in ARM or RUN is ignored.
- abort:
  - From ARM or RUN: del_out<=shadow base, upd=1, step_idx<=0, state<=IDLE. Sweep state is discarded; done stays 0.
  - In IDLE or DONE: no effect.
- Simultaneous events:
  - abort and start in the same cycle: abort wins.
  - abort and sync_edge in the same cycle: abort wins.
- upd is never high for two consecutive cycles.
- Asynchronous reset mid-sweep forces reset values immediately. The pulse generator then sees delay 0 until a new start.

Optional Feature:
- Macro SWEEP_LOOP_EN.
- Defined: at the sweep end, RUN does not go to DONE. Instead:
  - del_out<=shadow base, step_idx<=0, avg_cnt<=0, upd=1, state<=ARM.
  - The sweep repeats until abort.
  - ovf_err stays sticky across loops.
  - done is never asserted.
- Undefined: the sweep ends in DONE as described above.

Test Plan:
- Basic sweep:
  - Stimulus: base=100, step=10, n_steps=3, n_avg=2, then 8 sync pulses.
  - Required: del_out sequence 100→110→120; upd pulses at start, after the 3rd edge, and after the 5th edge.
  - Required: done after the 7th edge; step_idx ends at 2.
- Zero counts: n_steps=0, n_avg=0, base=50 → ARM, one discarded edge, then DONE on the next edge; del_out stays 50.
- Saturation: base=16'hFFF0, step=16'h0020, n_steps=2 → second point del_out=16'hFFFF, ovf_err=1; a new start clears ovf_err.
- Abort: abort during RUN at step_idx=1 (del_out=110) → next cycle del_out=100, upd=1, state IDLE, busy=0, done=0.
  - A simultaneous sync_edge is ignored.
- Ignored start: start during RUN does not change del_out or step_idx. Changing base_del mid-sweep does not affect the sweep.
- Reset and loop:
  - resetn low mid-RUN → all outputs 0 immediately.
  - With SWEEP_LOOP_EN and the basic-sweep stimulus: after the 7th edge del_out returns to 100 with upd=1, and the cycle repeats.
